cmp_arbiter: RTL and testbench

- Shares one Comparator8 instance between two requesters, typically ALU control and the branch/flag unit.
- Each requester presents an operand pair with a request.
- The arbiter grants one requester at a time, round-robin on ties, and registers the operands.
- It returns a registered GT/LT/EQ result tagged with the requester id, using a valid/ready handshake, and keeps saturating per-requester grant counts for performance monitoring.

---
 rtl/cmp_arb_pkg.sv | 13 +
 rtl/cmp_arbiter_comparator8.sv | 18 +
 rtl/cmp_arbiter.sv | 123 ++++++++++++
 tb/tb_cmp_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for the comparator arbiter.
package cmp_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic ID_REQ0 = 1'b0;
   localparam logic ID_REQ1 = 1'b1;

endpackage

// File: rtl/cmp_arbiter_comparator8.sv
// Unsigned magnitude comparator shared between the two requesters.
module Comparator8 #(
   parameter int WIDTH = 8
) (
   output logic             A_GT_B,
   output logic             A_LT_B,
   output logic             A_EQ_B,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B
);

   always_comb begin
      A_GT_B = (A > B);
      A_LT_B = (A < B);
      A_EQ_B = (A == B);
   end

endmodule

// File: rtl/cmp_arbiter.sv
// Two-requester round-robin arbiter in front of one Comparator8, with a
// registered valid/ready result and saturating per-requester grant counters.
//
//   state | meaning
//   IDLE  | waiting for a request; winner's operands captured on the edge
//   CMP   | comparator evaluates op_a/op_b; winner's gnt is high
//   HOLD  | result valid, held until res_ready
module cmp_arbiter
   import cmp_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             res_valid,
   output logic             res_id,
   output logic             res_gt,
   output logic             res_lt,
   output logic             res_eq,
   input  logic             res_ready,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state, state_nxt;
   logic [WIDTH-1:0] op_a, op_b;
   logic             id_r;
   logic             last_id;
   logic             req_any;
   logic             win_id;
   logic             cmp_gt, cmp_lt, cmp_eq;

   Comparator8 #(.WIDTH(WIDTH)) u_cmp (
      .A_GT_B (cmp_gt),
      .A_LT_B (cmp_lt),
      .A_EQ_B (cmp_eq),
      .A      (op_a),
      .B      (op_b)
   );

   always_comb begin
      req_any = req0 | req1;
      win_id  = ID_REQ0;
      if (req0 && req1) begin
         win_id = ~last_id;
      end else if (req1) begin
         win_id = ID_REQ1;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_any) state_nxt = CMP;
         CMP:     state_nxt = HOLD;
         HOLD:    if (res_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         id_r      <= ID_REQ0;
         last_id   <= ID_REQ1;
         gnt0      <= 1'b0;
         gnt1      <= 1'b0;
         res_valid <= 1'b0;
         res_id    <= 1'b0;
         res_gt    <= 1'b0;
         res_lt    <= 1'b0;
         res_eq    <= 1'b0;
         cnt0      <= '0;
         cnt1      <= '0;
      end else begin
         state <= state_nxt;
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_any) begin
                  op_a    <= (win_id == ID_REQ1) ? a1 : a0;
                  op_b    <= (win_id == ID_REQ1) ? b1 : b0;
                  id_r    <= win_id;
                  last_id <= win_id;
                  if (win_id == ID_REQ1) begin
                     gnt1 <= 1'b1;
                     if (cnt1 != '1) cnt1 <= cnt1 + CNT_ONE;
                  end else begin
                     gnt0 <= 1'b1;
                     if (cnt0 != '1) cnt0 <= cnt0 + CNT_ONE;
                  end
               end
            end
            CMP: begin
               res_gt    <= cmp_gt;
               res_lt    <= cmp_lt;
               res_eq    <= cmp_eq;
               res_id    <= id_r;
               res_valid <= 1'b1;
            end
            HOLD: begin
               if (res_ready) res_valid <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Directed-vector bench for cmp_arbiter; a second instance with CNT_W=2
// shares the stimulus to exercise counter saturation.
module tb_cmp_arbiter;

   logic       clk = 1'b0;
   logic       rst, req0, req1, res_ready;
   logic [7:0] a0, b0, a1, b1;

   logic        gnt0, gnt1, res_valid, res_id, res_gt, res_lt, res_eq;
   logic [15:0] cnt0, cnt1;
   logic        gnt0_s, gnt1_s, res_valid_s, res_id_s, res_gt_s, res_lt_s, res_eq_s;
   logic [1:0]  cnt0_s, cnt1_s;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   cmp_arbiter #(.WIDTH(8), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1),
      .res_valid(res_valid), .res_id(res_id),
      .res_gt(res_gt), .res_lt(res_lt), .res_eq(res_eq),
      .res_ready(res_ready), .cnt0(cnt0), .cnt1(cnt1)
   );

   cmp_arbiter #(.WIDTH(8), .CNT_W(2)) dut_s (
      .clk(clk), .rst(rst),
      .req0(req0), .a0(a0), .b0(b0),
      .req1(req1), .a1(a1), .b1(b1),
      .gnt0(gnt0_s), .gnt1(gnt1_s),
      .res_valid(res_valid_s), .res_id(res_id_s),
      .res_gt(res_gt_s), .res_lt(res_lt_s), .res_eq(res_eq_s),
      .res_ready(res_ready), .cnt0(cnt0_s), .cnt1(cnt1_s)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // One full transaction from a single requester with res_ready high.
   task automatic do_tx(input logic id, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] exp_gle);
      res_ready = 1'b1;
      if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
      else    begin req0 = 1'b1; a0 = a; b0 = b; end
      tick();
      chk("tx_gnt", {30'd0, gnt1, gnt0}, id ? 32'd2 : 32'd1);
      chk("tx_gnt_s", {30'd0, gnt1_s, gnt0_s}, id ? 32'd2 : 32'd1);
      req0 = 1'b0;
      req1 = 1'b0;
      a0 = 8'hFF; b0 = 8'hFF; a1 = 8'hFF; b1 = 8'hFF;
      tick();
      chk("tx_res", {27'd0, res_valid, res_id, res_gt, res_lt, res_eq},
          {27'd0, 1'b1, id, exp_gle});
      chk("tx_res_s", {27'd0, res_valid_s, res_id_s, res_gt_s, res_lt_s, res_eq_s},
          {27'd0, 1'b1, id, exp_gle});
      tick();
      chk("tx_drop", {31'd0, res_valid}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; req0 = 1'b0; req1 = 1'b0; res_ready = 1'b1;
      a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      do_reset();
      chk("reset_out", {25'd0, gnt0, gnt1, res_valid, res_id, res_gt, res_lt, res_eq}, 32'd0);
      chk("reset_cnt", {cnt0, cnt1}, 32'd0);

      // Single request, A<B
      do_tx(1'b0, 8'h31, 8'h34, 3'b010);
      chk("single_cnt0", {16'd0, cnt0}, 32'd1);

      // Simultaneous requests after reset: req0 wins first
      do_reset();
      req0 = 1'b1; a0 = 8'h87; b0 = 8'h1A;
      req1 = 1'b1; a1 = 8'hFE; b1 = 8'hFF;
      tick();
      chk("sim_gnt_a", {30'd0, gnt1, gnt0}, 32'd1);
      req0 = 1'b0;
      tick();
      chk("sim_res_a", {27'd0, res_valid, res_id, res_gt, res_lt, res_eq}, 32'b1_0_100);
      chk("sim_gnt_a_off", {30'd0, gnt1, gnt0}, 32'd0);
      tick();
      chk("sim_drop_a", {31'd0, res_valid}, 32'd0);
      tick();
      chk("sim_gnt_b", {30'd0, gnt1, gnt0}, 32'd2);
      req1 = 1'b0;
      tick();
      chk("sim_res_b", {27'd0, res_valid, res_id, res_gt, res_lt, res_eq}, 32'b1_1_010);
      tick();
      chk("sim_cnt", {cnt0, cnt1}, {16'd1, 16'd1});

      // Fairness: both held high over four transactions
      do_reset();
      req0 = 1'b1; a0 = 8'h05; b0 = 8'h03;
      req1 = 1'b1; a1 = 8'h03; b1 = 8'h05;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("fair_gnt", {30'd0, gnt1, gnt0}, (i % 2 == 0) ? 32'd1 : 32'd2);
         if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
         tick();
         chk("fair_id", {31'd0, res_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
         tick();
      end
      chk("fair_cnt", {cnt0, cnt1}, {16'd2, 16'd2});

      // Backpressure: result held, req1 ignored until accept
      do_reset();
      req0 = 1'b1; a0 = 8'h10; b0 = 8'h20;
      tick();
      chk("bp_gnt0", {30'd0, gnt1, gnt0}, 32'd1);
      req0 = 1'b0; req1 = 1'b1; a1 = 8'h44; b1 = 8'h22;
      res_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         a0 = 8'h20 + 8'(i);
         chk("bp_hold", {26'd0, gnt1, res_valid, res_id, res_gt, res_lt, res_eq}, 32'b0_1_0_010);
         tick();
      end
      res_ready = 1'b1;
      tick();
      chk("bp_accept", {30'd0, res_valid, gnt1}, 32'd0);
      tick();
      chk("bp_gnt1", {30'd0, gnt1, gnt0}, 32'd2);
      req1 = 1'b0;
      tick();
      chk("bp_res1", {27'd0, res_valid, res_id, res_gt, res_lt, res_eq}, 32'b1_1_100);
      tick();

      // Equality, zero and unsigned boundaries
      do_tx(1'b0, 8'h61, 8'h61, 3'b001);
      do_tx(1'b0, 8'h00, 8'h00, 3'b001);
      do_tx(1'b0, 8'h00, 8'h01, 3'b010);
      do_tx(1'b1, 8'h80, 8'h7F, 3'b100);

      // Reset while in CMP
      do_reset();
      req0 = 1'b1; a0 = 8'h09; b0 = 8'h01;
      tick();
      chk("rst_cmp_gnt", {31'd0, gnt0}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; req0 = 1'b0;
      chk("rst_cmp_out", {29'd0, gnt0, gnt1, res_valid}, 32'd0);
      chk("rst_cmp_cnt", {cnt0, cnt1}, 32'd0);
      tick();
      chk("rst_cmp_idle", {29'd0, gnt0, gnt1, res_valid}, 32'd0);
      do_tx(1'b0, 8'h09, 8'h01, 3'b100);
      chk("rst_cmp_cnt1", {cnt0, cnt1}, {16'd1, 16'd0});

      // Saturation with CNT_W=2
      do_reset();
      for (int i = 0; i < 5; i++) do_tx(1'b0, 8'(i), 8'h02, (i < 2) ? 3'b010 : (i == 2) ? 3'b001 : 3'b100);
      chk("sat_cnt0_wide", {16'd0, cnt0}, 32'd5);
      chk("sat_cnt0_narrow", {30'd0, cnt0_s}, 32'd3);
      chk("sat_cnt1_narrow", {30'd0, cnt1_s}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
